// File: rtl/frame_builder.sv
// Response-frame serializer: latches a command/status/address/data on start_frame and
// streams SOF, status, cmd, optional little-endian addr/data, and a CRC-8 (poly 0x07) to the TX FIFO.
module frame_builder (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cmd,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [7:0]  error_status,
  input  logic        start_frame,
  output logic [7:0]  tx_fifo_data,
  output logic        tx_fifo_write,
  input  logic        tx_fifo_full
);

  localparam logic [7:0] SOF_BYTE = 8'h5A;
  localparam logic [7:0] CMD_READ = 8'hA1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_STATUS = 3'd2,
    ST_CMD    = 3'd3,
    ST_ADDR   = 3'd4,
    ST_DATA   = 3'd5,
    ST_CRC    = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  state_e      current_state, state_d;
  logic [7:0]  calculated_crc, crc_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  status_q, status_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  idx_q, idx_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] b);
    logic [7:0] c;
    c = crc_in ^ b;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current_state  <= ST_IDLE;
      calculated_crc <= '0;
      cmd_q          <= '0;
      status_q       <= '0;
      addr_q         <= '0;
      data_q         <= '0;
      idx_q          <= '0;
    end else begin
      current_state  <= state_d;
      calculated_crc <= crc_d;
      cmd_q          <= cmd_d;
      status_q       <= status_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      idx_q          <= idx_d;
    end
  end

  always_comb begin
    state_d       = current_state;
    crc_d         = calculated_crc;
    cmd_d         = cmd_q;
    status_d      = status_q;
    addr_d        = addr_q;
    data_d        = data_q;
    idx_d         = idx_q;
    tx_fifo_write = 1'b0;
    tx_fifo_data  = '0;

    unique case (current_state)
      ST_IDLE: begin
        if (start_frame) begin
          cmd_d    = cmd;
          status_d = error_status;
          addr_d   = addr;
          data_d   = data;
          crc_d    = '0;
          idx_d    = '0;
          state_d  = ST_SOF;
        end
      end
      ST_SOF: begin
        tx_fifo_data  = SOF_BYTE;
        tx_fifo_write = !tx_fifo_full;
        if (tx_fifo_write) state_d = ST_STATUS;
      end
      ST_STATUS: begin
        tx_fifo_data  = status_q;
        tx_fifo_write = !tx_fifo_full;
        if (tx_fifo_write) begin
          crc_d   = crc8_byte(calculated_crc, status_q);
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        tx_fifo_data  = cmd_q;
        tx_fifo_write = !tx_fifo_full;
        if (tx_fifo_write) begin
          crc_d   = crc8_byte(calculated_crc, cmd_q);
          idx_d   = '0;
          state_d = (cmd_q == CMD_READ) ? ST_ADDR : ST_CRC;
        end
      end
      ST_ADDR: begin
        tx_fifo_data  = addr_q[{idx_q, 3'b000} +: 8];
        tx_fifo_write = !tx_fifo_full;
        if (tx_fifo_write) begin
          crc_d = crc8_byte(calculated_crc, tx_fifo_data);
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_fifo_data  = data_q[{idx_q, 3'b000} +: 8];
        tx_fifo_write = !tx_fifo_full;
        if (tx_fifo_write) begin
          crc_d = crc8_byte(calculated_crc, tx_fifo_data);
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        tx_fifo_data  = calculated_crc;
        tx_fifo_write = !tx_fifo_full;
        if (tx_fifo_write) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_builder.sv
// Scoreboard bench for frame_builder: expected bytes are queued at request time and a
// negedge monitor pops and compares every byte the DUT writes.
module tb_frame_builder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  cmd = '0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;
  logic [7:0]  error_status = '0;
  logic        start_frame = 1'b0;
  logic [7:0]  tx_fifo_data;
  logic        tx_fifo_write;
  logic        tx_fifo_full = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          n_written = 0;
  int          full_mode = 0;
  logic [7:0]  exp_q[$];

  frame_builder dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd),
    .addr         (addr),
    .data         (data),
    .error_status (error_status),
    .start_frame  (start_frame),
    .tx_fifo_data (tx_fifo_data),
    .tx_fifo_write(tx_fifo_write),
    .tx_fifo_full (tx_fifo_full)
  );

  always #5 clk = ~clk;

  // full_mode: 0 = never full, 1 = always full, 2 = random backpressure
  always @(posedge clk) begin
    #1;
    case (full_mode)
      1:       tx_fifo_full = 1'b1;
      2:       tx_fifo_full = ($urandom_range(0, 2) == 0);
      default: tx_fifo_full = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (tx_fifo_full) begin
      checks++;
      if (tx_fifo_write !== 1'b0) begin
        failures++;
        $display("FAIL write_while_full: tx_fifo_write=%b required 0", tx_fifo_write);
      end
    end
    if (tx_fifo_write === 1'b1) begin
      n_written++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte: got 0x%02h with nothing expected", tx_fifo_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_fifo_data !== e) begin
          failures++;
          $display("FAIL frame_byte: got 0x%02h required 0x%02h", tx_fifo_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Bit-serial CRC-8 long division over the message, MSB first.
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    logic [7:0] c = '0;
    logic       fb;
    foreach (msg[k]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ msg[k][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic push_model(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] s);
    logic [7:0] body[$];
    body.push_back(s);
    body.push_back(c);
    if (c == 8'hA1) begin
      for (int i = 0; i < 4; i++) body.push_back(a[8*i +: 8]);
      for (int i = 0; i < 4; i++) body.push_back(d[8*i +: 8]);
    end
    exp_q.push_back(8'h5A);
    foreach (body[k]) exp_q.push_back(body[k]);
    exp_q.push_back(model_crc(body));
  endtask

  task automatic pulse_start(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                             input logic [7:0] s, input bit lat_chk);
    @(posedge clk); #1;
    cmd = c; addr = a; data = d; error_status = s; start_frame = 1'b1;
    @(posedge clk); #1;
    start_frame = 1'b0;
    cmd = $urandom; addr = $urandom; data = $urandom; error_status = $urandom;
    if (lat_chk) begin
      @(negedge clk);
      check("first_write_latency", {31'd0, tx_fifo_write}, 32'd1);
    end
  endtask

  // Drains the current frame; optionally pulses junk start_frame requests mid-frame.
  task automatic wait_idle(input bit junk);
    bit done = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(posedge clk); #2;
      if (start_frame) start_frame = 1'b0;
      else if (junk && dut.current_state != 3'd0 && $urandom_range(0, 4) == 0) begin
        cmd = 8'hA1; addr = $urandom; data = $urandom; error_status = $urandom;
        start_frame = 1'b1;
      end
      if (!start_frame && exp_q.size() == 0 && dut.current_state == 3'd0) done = 1;
    end
    check("frame_drained", {31'd0, done}, 32'd1);
    check("bytes_left", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  c, s;
    logic [31:0] a, d;
    int          base;
    bit          hit;

    #1;
    check("reset_write", {31'd0, tx_fifo_write}, 32'd0);
    check("reset_data", {24'd0, tx_fifo_data}, 32'd0);
    check("reset_state", {29'd0, dut.current_state}, 32'd0);
    check("reset_crc", {24'd0, dut.calculated_crc}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Read response
    push_model(8'hA1, 32'h12345678, 32'hDEADBEEF, 8'h00);
    pulse_start(8'hA1, 32'h12345678, 32'hDEADBEEF, 8'h00, 1'b1);
    wait_idle(1'b0);

    // Write response, literal frame
    exp_q = '{8'h5A, 8'h00, 8'hA2, 8'h67};
    pulse_start(8'hA2, 32'h87654321, 32'h12345678, 8'h00, 1'b1);
    wait_idle(1'b0);

    // Error response, literal frame
    exp_q = '{8'h5A, 8'h01, 8'hAE, 8'h56};
    pulse_start(8'hAE, 32'h0, 32'h0, 8'h01, 1'b1);
    wait_idle(1'b0);

    // Full asserted before start: frame waits in SOF
    full_mode = 1;
    @(posedge clk);
    push_model(8'hA1, 32'hAAAAAAAA, 32'hBBBBBBBB, 8'h00);
    base = n_written;
    pulse_start(8'hA1, 32'hAAAAAAAA, 32'hBBBBBBBB, 8'h00, 1'b0);
    repeat (20) @(negedge clk);
    check("stall_no_writes", n_written - base, 32'd0);
    check("stall_state_sof", {29'd0, dut.current_state}, 32'd1);
    full_mode = 0;
    wait_idle(1'b0);

    // Random frames with random backpressure and ignored mid-frame starts
    full_mode = 2;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: c = 8'hA2;
        1: c = 8'hAE;
        2: c = $urandom;
        default: c = 8'hA1;
      endcase
      a = $urandom; d = $urandom; s = $urandom;
      push_model(c, a, d, s);
      pulse_start(c, a, d, s, 1'b0);
      wait_idle(1'b1);
    end
    full_mode = 0;
    @(posedge clk);

    // Reset in the middle of a read frame
    push_model(8'hA1, 32'h01020304, 32'h05060708, 8'h33);
    base = n_written;
    pulse_start(8'hA1, 32'h01020304, 32'h05060708, 8'h33, 1'b0);
    hit = 0;
    for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
      @(negedge clk);
      if (n_written - base >= 5) hit = 1;
    end
    check("reached_byte5", {31'd0, hit}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midreset_write", {31'd0, tx_fifo_write}, 32'd0);
    check("midreset_data", {24'd0, tx_fifo_data}, 32'd0);
    check("midreset_state", {29'd0, dut.current_state}, 32'd0);
    check("midreset_crc", {24'd0, dut.calculated_crc}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    a = $urandom; d = $urandom;
    push_model(8'hA1, a, d, 8'h5C);
    pulse_start(8'hA1, a, d, 8'h5C, 1'b1);
    wait_idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
